l1_cache: RTL and testbench
===========================

// Module: l1_cache
// PURPOSE
//  2-way set-associative, write-back, write-allocate unified cache between the multicycle
//  RV32I control/datapath (mem_read/mem_write/mem_byte_enable/mem_resp) and physical memory.
//  Serves 32-bit word accesses from 256-bit lines. Refills and evicts whole lines over a
//  single-request pmem handshake.
// PARAMETERS
//  S_INDEX  3  set-index bits; sets = 2**S_INDEX; tag = 32-5-S_INDEX bits (line = 32 B)
// PORTS
//  clk               in   1    clock, all state updates on posedge
//  rst               in   1    synchronous, active-high reset
//  mem_address       in   32   CPU byte address; [4:2] word select, [1:0] ignored
//  mem_read          in   1    CPU read request, held until mem_resp
//  mem_write         in   1    CPU write request, held until mem_resp
//  mem_byte_enable   in   4    byte lanes written on mem_write
//  mem_wdata         in   32   CPU write data
//  mem_rdata         out  32   read data, valid while mem_resp=1
//  mem_resp          out  1    one-cycle completion pulse
//  pmem_address      out  32   line-aligned address ([4:0]=0)
//  pmem_read         out  1    line refill request, held until pmem_resp
//  pmem_write        out  1    line writeback request, held until pmem_resp
//  pmem_wdata        out  256  evicted line
//  pmem_rdata        in   256  refill line, valid while pmem_resp=1
//  pmem_resp         in   1    pmem completion pulse
//  perf_hits         out  32   hit count (see CONFIGURATION)
//  perf_misses       out  32   miss count (see CONFIGURATION)
// BEHAVIOUR
//  - Per set: valid[2], dirty[2], tag[2], data[2] (256 b), lru (1 = way 1 is LRU).
//    Arrays read synchronously, addressed by mem_address index.
//  - FSM: IDLE -> CHECK -> {IDLE | WB | ALLOC}; WB -> ALLOC; ALLOC -> IDLE.
//    IDLE: if mem_read|mem_write, go to CHECK (arrays read this cycle).
//    CHECK: hit = valid&&tag match in either way.
//      Hit read: mem_resp=1, mem_rdata=word[addr[4:2]], lru=other way.
//      Hit write: merge mem_wdata bytes per mem_byte_enable, set dirty, update lru, mem_resp=1.
//      Hit -> IDLE. Miss: victim = lru way; victim valid&dirty -> WB, else -> ALLOC.
//    WB: pmem_write=1, pmem_address={victim tag,index,5'b0}, pmem_wdata=victim line.
//      Held until pmem_resp, then -> ALLOC.
//    ALLOC: pmem_read=1, pmem_address={addr tag,index,5'b0}. On pmem_resp write line to
//      victim, valid=1, dirty=0, tag=addr tag. -> IDLE; the still-held request re-enters
//      CHECK and hits.
//  - Latency: hit = 2 cycles from request to mem_resp. Miss = hit + refill (+ writeback).
//  - mem_resp is a single-cycle pulse. Request drops the cycle after; IDLE never re-triggers it.
//  - mem_read&&mem_write together: treated as write.
//  - Both ways invalid: victim = way 0 (lru reset value 0). Only one way valid: victim = invalid way.
//  - pmem_read/pmem_write are never both 1. Outputs are Moore (from state) except mem_rdata.
//  - Reset: state=IDLE; valid, dirty, lru all cleared; mem_resp, pmem_read, pmem_write = 0
//    the cycle after the reset edge. Data/tag arrays not reset.
//  - Reset mid-WB/ALLOC aborts: the pmem request drops and the line is not installed.
//  - mem_rdata is 0 when mem_resp=0.
// CONFIGURATION
//  L1_CACHE_PERF_CNT_EN defined:
//    - perf_hits increments on each first-pass CHECK hit.
//    - perf_misses increments on each CHECK miss. A post-refill re-CHECK hit is not counted.
//    - Both counters 32-bit wrapping, cleared by rst.
//  L1_CACHE_PERF_CNT_EN undefined: no counter logic; perf_hits/perf_misses tied to 0.
// STRUCTURE
//  - Package cache_types: cache_state_t enum {IDLE,CHECK,WB,ALLOC}; LINE_BITS=256;
//    OFFSET_BITS=5; helper functions tag_of/index_of/word_sel.
//  - Sub-module cache_array #(WIDTH,S_INDEX): sync-read, write-enable RAM.
//    Instanced for tag, data, valid, dirty per way; lru is a flop vector in l1_cache.
// TESTING
//  - Cold read 0x0000_0040 -> ALLOC with pmem_address=0x40, no WB; mem_resp 2 cycles after
//    refill; rdata=word 0.
//  - Re-read 0x0000_0044 -> hit, mem_resp exactly 2 cycles after mem_read, no pmem activity.
//  - Write 0x0000_0044, be=4'b0010, wdata=0xAABBCCDD -> hit.
//    Read back = old word with byte1=0xCC; dirty set.
//  - Fill set 2 with tags A then B, dirty A, access tag C -> WB pmem_address={A,2,0} with the
//    written line; ALLOC={C,2,0}; B retained.
//  - Assert rst during ALLOC (pmem_resp withheld) -> pmem_read=0 next cycle.
//    Re-read same address -> misses again.
//  - With L1_CACHE_PERF_CNT_EN: sequence miss,hit,hit,miss -> perf_hits=2, perf_misses=2.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and address helpers for the l1_cache block: FSM states, line geometry
// and tag/index/word extraction from a 32-bit byte address.
package cache_types;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int WORD_BITS   = 32;

  typedef enum logic [1:0] {IDLE, CHECK, WB, ALLOC} cache_state_t;

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int s_index);
    return addr >> (OFFSET_BITS + s_index);
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int s_index);
    return (addr >> OFFSET_BITS) & ((32'd1 << s_index) - 32'd1);
  endfunction

  function automatic logic [2:0] word_sel(input logic [31:0] addr);
    return 3'((addr >> 2) & 32'h7);
  endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Synchronous-read, single-write-port RAM used for the per-way tag/data/valid/dirty arrays.
// RST_EN=1 clears every entry on rst (valid/dirty bits); data and tag arrays leave it at 0.
module cache_array #(
  parameter int WIDTH   = 1,
  parameter int S_INDEX = 3,
  parameter bit RST_EN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [S_INDEX-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [S_INDEX-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  localparam int DEPTH = 1 << S_INDEX;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (RST_EN && rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/l1_cache.sv
// 2-way set-associative, write-back, write-allocate L1 cache (32 B lines, 32-bit CPU port).
// Optional hit/miss performance counters are built when L1_CACHE_PERF_CNT_EN is defined.
module l1_cache
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
);

  localparam int TAG_W = 32 - OFFSET_BITS - S_INDEX;
  localparam int SETS  = 1 << S_INDEX;

  cache_state_t state, state_nxt;

  logic [S_INDEX-1:0]   idx;
  logic [TAG_W-1:0]     addr_tag;
  logic [2:0]           wsel;

  logic [TAG_W-1:0]     tag_rd_p1   [2];
  logic [LINE_BITS-1:0] data_rd_p1  [2];
  logic                 valid_rd_p1 [2];
  logic                 dirty_rd_p1 [2];

  logic [1:0]           tag_we, data_we, valid_we, dirty_we;
  logic [LINE_BITS-1:0] data_wd;
  logic                 dirty_wd;

  logic [SETS-1:0]      lru;
  logic                 victim_sel, victim_q;
  logic                 hit0, hit1, hit, hit_way;
  logic [LINE_BITS-1:0] hit_line, merged_line;
  logic [31:0]          hit_word;

  assign idx      = S_INDEX'(index_of(mem_address, S_INDEX));
  assign addr_tag = TAG_W'(tag_of(mem_address, S_INDEX));
  assign wsel     = word_sel(mem_address);

  // p0 -> p1: arrays are read at the request index, results are valid in CHECK
  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_array #(.WIDTH(TAG_W), .S_INDEX(S_INDEX), .RST_EN(1'b0)) u_tag (
      .clk(clk), .rst(rst), .we(tag_we[w]), .waddr(idx), .wdata(addr_tag),
      .raddr(idx), .rdata(tag_rd_p1[w])
    );
    cache_array #(.WIDTH(LINE_BITS), .S_INDEX(S_INDEX), .RST_EN(1'b0)) u_data (
      .clk(clk), .rst(rst), .we(data_we[w]), .waddr(idx), .wdata(data_wd),
      .raddr(idx), .rdata(data_rd_p1[w])
    );
    cache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RST_EN(1'b1)) u_valid (
      .clk(clk), .rst(rst), .we(valid_we[w]), .waddr(idx), .wdata(1'b1),
      .raddr(idx), .rdata(valid_rd_p1[w])
    );
    cache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RST_EN(1'b1)) u_dirty (
      .clk(clk), .rst(rst), .we(dirty_we[w]), .waddr(idx), .wdata(dirty_wd),
      .raddr(idx), .rdata(dirty_rd_p1[w])
    );
  end

  always_comb begin
    hit0     = valid_rd_p1[0] && (tag_rd_p1[0] == addr_tag);
    hit1     = valid_rd_p1[1] && (tag_rd_p1[1] == addr_tag);
    hit      = hit0 || hit1;
    hit_way  = hit1;
    hit_line = hit1 ? data_rd_p1[1] : data_rd_p1[0];
    hit_word = hit_line[{wsel, 5'b00000} +: 32];
    // An invalid way is always filled before anything is evicted
    if (!valid_rd_p1[0])      victim_sel = 1'b0;
    else if (!valid_rd_p1[1]) victim_sel = 1'b1;
    else                      victim_sel = lru[idx];
  end

  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged_line[{wsel, 2'(b), 3'b000} +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (mem_read || mem_write) state_nxt = CHECK;
      CHECK: begin
        if (hit)                                                   state_nxt = IDLE;
        else if (valid_rd_p1[victim_sel] && dirty_rd_p1[victim_sel]) state_nxt = WB;
        else                                                       state_nxt = ALLOC;
      end
      WB:    if (pmem_resp) state_nxt = ALLOC;
      ALLOC: if (pmem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Array writes: hit-write merge in CHECK, line install at the end of ALLOC
  always_comb begin
    tag_we   = 2'b00;
    data_we  = 2'b00;
    valid_we = 2'b00;
    dirty_we = 2'b00;
    dirty_wd = 1'b0;
    data_wd  = merged_line;
    if (!rst) begin
      if (state == CHECK && hit && mem_write) begin
        data_we[hit_way]  = 1'b1;
        dirty_we[hit_way] = 1'b1;
        dirty_wd          = 1'b1;
      end else if (state == ALLOC && pmem_resp) begin
        data_wd            = pmem_rdata;
        data_we[victim_q]  = 1'b1;
        tag_we[victim_q]   = 1'b1;
        valid_we[victim_q] = 1'b1;
        dirty_we[victim_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lru      <= '0;
      victim_q <= 1'b0;
    end else if (state == CHECK) begin
      victim_q <= victim_sel;
      if (hit) lru[idx] <= ~hit_way;
    end
  end

  always_comb begin
    mem_resp     = (state == CHECK) && hit;
    mem_rdata    = mem_resp ? hit_word : 32'h0;
    pmem_read    = (state == ALLOC);
    pmem_write   = (state == WB);
    pmem_wdata   = data_rd_p1[victim_q];
    pmem_address = {addr_tag, idx, {OFFSET_BITS{1'b0}}};
    if (state == WB) pmem_address = {tag_rd_p1[victim_q], idx, {OFFSET_BITS{1'b0}}};
  end

`ifdef L1_CACHE_PERF_CNT_EN
  logic        refilled_q;
  logic [31:0] hits_q, misses_q;

  // The re-CHECK that follows a refill is the tail of a miss, not a fresh hit
  always_ff @(posedge clk) begin
    if (rst) begin
      refilled_q <= 1'b0;
      hits_q     <= '0;
      misses_q   <= '0;
    end else begin
      if (state == ALLOC && pmem_resp) refilled_q <= 1'b1;
      else if (state == CHECK)         refilled_q <= 1'b0;
      if (state == CHECK) begin
        if (!hit)             misses_q <= misses_q + 32'd1;
        else if (!refilled_q) hits_q   <= hits_q + 32'd1;
      end
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`else
  assign perf_hits   = 32'h0;
  assign perf_misses = 32'h0;
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: vector table of CPU accesses against a latency-3 pmem model,
// plus hand sequences for reset state, writeback contents and reset during refill.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  perf_hits, perf_misses;

  l1_cache #(.S_INDEX(3)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  always #5 clk = ~clk;

  int ntests = 0, nfail = 0;
  int nrd = 0, nwr = 0, both_err = 0, rdata_leak = 0, pulse_err = 0;
  int exp_hits = 0, exp_misses = 0;
  bit pmem_hold = 1'b0;
  logic [31:0]  last_rd_pa, last_wb_pa;
  logic [255:0] last_wb_data;
  logic [255:0] pmem_store [logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_pa;
    logic [31:0] exp_wb_pa;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA000_0000 + la + 32'(w);
    return l;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input bit rd, input bit wr,
                              input logic [3:0] be, input logic [31:0] wd, input bit chk,
                              input logic [31:0] er, input int lat, input int xr, input int xw,
                              input logic [31:0] pa, input logic [31:0] wpa);
    vec_t v;
    v.addr = a; v.rd = rd; v.wr = wr; v.be = be; v.wdata = wd; v.chk = chk;
    v.exp_rdata = er; v.exp_lat = lat; v.exp_nrd = xr; v.exp_nwr = xw;
    v.exp_pa = pa; v.exp_wb_pa = wpa;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line-granular memory: responds 3 cycles after a request is first seen
  initial begin : pmem_model
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) both_err++;
      if ((pmem_read || pmem_write) && !pmem_hold) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            pmem_store[pmem_address] = pmem_wdata;
            last_wb_pa = pmem_address;
            last_wb_data = pmem_wdata;
            nwr++;
          end else begin
            pmem_rdata = pmem_store.exists(pmem_address) ? pmem_store[pmem_address]
                                                         : init_line(pmem_address);
            last_rd_pa = pmem_address;
            nrd++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic access(input logic [31:0] a, input bit rd, input bit wr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
    lat = 1;
    rdata = '0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) break;
      if (mem_rdata !== 32'h0) rdata_leak++;
      if (lat > 100) break;
    end
    rdata = mem_rdata;
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (mem_resp !== 1'b0) pulse_err++;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int rd0, wr0, lat;
    logic [31:0] rdata;
    rd0 = nrd;
    wr0 = nwr;
    access(v.addr, v.rd, v.wr, v.be, v.wdata, rdata, lat);
    check({tag, " latency"}, 256'(lat), 256'(v.exp_lat));
    if (v.chk) check({tag, " rdata"}, 256'(rdata), 256'(v.exp_rdata));
    check({tag, " refills"}, 256'(nrd - rd0), 256'(v.exp_nrd));
    check({tag, " writebacks"}, 256'(nwr - wr0), 256'(v.exp_nwr));
    if (v.exp_nrd > 0) check({tag, " alloc addr"}, 256'(last_rd_pa), 256'(v.exp_pa));
    if (v.exp_nwr > 0) check({tag, " wb addr"}, 256'(last_wb_pa), 256'(v.exp_wb_pa));
    if (v.exp_lat == 2) exp_hits++;
    else                exp_misses++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [255:0] exp_line;
    int waited;

    //                addr          rd wr be       wdata         chk rdata         lat rd wr pa            wb pa
    vecs[0]  = mk(32'h0000_0040, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_0040, 7,  1, 0, 32'h0000_0040, 32'h0);
    vecs[1]  = mk(32'h0000_0044, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_0041, 2,  0, 0, 32'h0,         32'h0);
    vecs[2]  = mk(32'h0000_0044, 0, 1, 4'b0010, 32'hAABBCCDD, 0, 32'h0,         2,  0, 0, 32'h0,         32'h0);
    vecs[3]  = mk(32'h0000_0044, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_CC41, 2,  0, 0, 32'h0,         32'h0);
    vecs[4]  = mk(32'h0000_0140, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_0140, 7,  1, 0, 32'h0000_0140, 32'h0);
    vecs[5]  = mk(32'h0000_0240, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_0240, 10, 1, 1, 32'h0000_0240, 32'h0000_0040);
    vecs[6]  = mk(32'h0000_0144, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_0141, 2,  0, 0, 32'h0,         32'h0);
    vecs[7]  = mk(32'h0000_0044, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_CC41, 7,  1, 0, 32'h0000_0040, 32'h0);
    vecs[8]  = mk(32'h0000_0040, 0, 1, 4'b1111, 32'h12345678, 0, 32'h0,         2,  0, 0, 32'h0,         32'h0);
    vecs[9]  = mk(32'h0000_0040, 1, 0, 4'b0000, 32'h0,        1, 32'h1234_5678, 2,  0, 0, 32'h0,         32'h0);
    vecs[10] = mk(32'h0000_0060, 0, 1, 4'b1001, 32'h11223344, 0, 32'h0,         7,  1, 0, 32'h0000_0060, 32'h0);
    vecs[11] = mk(32'h0000_0060, 1, 0, 4'b0000, 32'h0,        1, 32'h1100_0044, 2,  0, 0, 32'h0,         32'h0);
    vecs[12] = mk(32'h0000_0064, 1, 1, 4'b0001, 32'h000000FF, 0, 32'h0,         2,  0, 0, 32'h0,         32'h0);
    vecs[13] = mk(32'h0000_0064, 1, 0, 4'b0000, 32'h0,        1, 32'hA000_00FF, 2,  0, 0, 32'h0,         32'h0);

    rst = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset mem_resp", 256'(mem_resp), 256'(0));
    check("reset pmem_read", 256'(pmem_read), 256'(0));
    check("reset pmem_write", 256'(pmem_write), 256'(0));
    check("reset perf_hits", 256'(perf_hits), 256'(0));
    check("reset perf_misses", 256'(perf_misses), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    exp_line = init_line(32'h0000_0040);
    exp_line[32 +: 32] = 32'hA000_CC41;
    check("wb line data", last_wb_data, exp_line);
`ifdef L1_CACHE_PERF_CNT_EN
    check("perf_hits table", 256'(perf_hits), 256'(exp_hits));
    check("perf_misses table", 256'(perf_misses), 256'(exp_misses));
`else
    check("perf_hits tied", 256'(perf_hits), 256'(0));
    check("perf_misses tied", 256'(perf_misses), 256'(0));
`endif

    // Reset while ALLOC waits on a withheld refill
    @(negedge clk);
    pmem_hold = 1'b1;
    mem_address = 32'h0000_0080; mem_read = 1'b1; mem_byte_enable = '0;
    waited = 0;
    while (pmem_read !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("alloc started", 256'(pmem_read), 256'(1));
    @(negedge clk);
    rst = 1'b1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    check("abort pmem_read", 256'(pmem_read), 256'(0));
    check("abort pmem_write", 256'(pmem_write), 256'(0));
    check("abort mem_resp", 256'(mem_resp), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    pmem_hold = 1'b0;
    check("post-reset perf_hits", 256'(perf_hits), 256'(0));
    check("post-reset perf_misses", 256'(perf_misses), 256'(0));

    exp_hits = 0;
    exp_misses = 0;
    run_vec(mk(32'h0000_0080, 1, 0, 4'b0, 32'h0, 1, 32'hA000_0080, 7, 1, 0, 32'h0000_0080, 32'h0), "rst reread");
    run_vec(mk(32'h0000_0084, 1, 0, 4'b0, 32'h0, 1, 32'hA000_0081, 2, 0, 0, 32'h0, 32'h0), "seq hit1");
    run_vec(mk(32'h0000_0088, 1, 0, 4'b0, 32'h0, 1, 32'hA000_0082, 2, 0, 0, 32'h0, 32'h0), "seq hit2");
    run_vec(mk(32'h0000_00A0, 1, 0, 4'b0, 32'h0, 1, 32'hA000_00A0, 7, 1, 0, 32'h0000_00A0, 32'h0), "seq miss2");
`ifdef L1_CACHE_PERF_CNT_EN
    check("perf_hits seq", 256'(perf_hits), 256'(2));
    check("perf_misses seq", 256'(perf_misses), 256'(2));
`else
    check("perf_hits seq tied", 256'(perf_hits), 256'(0));
    check("perf_misses seq tied", 256'(perf_misses), 256'(0));
`endif

    check("pmem read+write overlap", 256'(both_err), 256'(0));
    check("rdata nonzero without resp", 256'(rdata_leak), 256'(0));
    check("mem_resp longer than one cycle", 256'(pulse_err), 256'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
